warp_dispatcher: RTL and testbench

- Sits directly downstream of the warp scheduler.
- Accepts launched kernels (`valid_kernel`/`kernel_t`) into a small skid FIFO and assigns each to an idle SIMD core using a round-robin policy.
- Drives per-core start/PC/thread-mask/warp-id, tracks each core through completion, and returns the per-core `finished_warp_id` vector the scheduler consumes (4'b1111 = none).

---
 rtl/warp_dispatcher_pkg.sv | 22 ++
 rtl/circular_buffer.sv | 45 ++++
 rtl/warp_dispatcher_core_slot.sv | 67 ++++++
 rtl/warp_dispatcher.sv | 112 +++++++++++
 tb/tb_warp_dispatcher.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/warp_dispatcher_pkg.sv
// rtl/warp_dispatcher_pkg.sv - shared kernel descriptor, core/lane sizing and lane-mask helper
package warp_dispatcher_pkg;
  localparam int NUM_SIMD_CORES    = 4;
  localparam int LOG2_SIMD_CORES   = 2;
  localparam int THREAD_COUNT      = 8;
  localparam int LOG2_THREAD_COUNT = 3;

  localparam logic [3:0] NO_WARP = 4'b1111;

  typedef struct packed {
    logic [31:0]                  start_pc;
    logic [LOG2_THREAD_COUNT-1:0] thread_count;
    logic [3:0]                   warp_id;
  } kernel_t;

  // (1 << count) - 1 evaluated at lane width, so count = THREAD_COUNT-1 gives all but the top lane.
  function automatic logic [THREAD_COUNT-1:0] lane_mask(input logic [LOG2_THREAD_COUNT-1:0] count);
    logic [THREAD_COUNT-1:0] one;
    one = THREAD_COUNT'(1);
    return (one << count) - one;
  endfunction
endpackage

// File: rtl/circular_buffer.sv
// rtl/circular_buffer.sv - power-of-two FIFO; a push on a full buffer lands only when a pop happens the same cycle
module circular_buffer #(
  parameter int  SIZE = 4,
  parameter type T    = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     data_in,
  input  logic pop,
  output T     data_out,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(SIZE);

  T               mem [SIZE];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == (AW+1)'(SIZE));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/warp_dispatcher_core_slot.sv
// rtl/warp_dispatcher_core_slot.sv - core_slot: per-core launch/run/retire tracker
module core_slot
  import warp_dispatcher_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    grant,
  input  kernel_t                 kernel,
  input  logic                    done,
  output logic                    idle,
  output logic                    start,
  output logic [31:0]             pc,
  output logic [THREAD_COUNT-1:0] thread_mask,
  output logic [3:0]              warp_id,
  output logic [3:0]              finished_warp_id
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUNNING, RETIRE} slot_state_t;

  slot_state_t state;
  slot_state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    idle             = 1'b0;
    start            = 1'b0;
    finished_warp_id = NO_WARP;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (grant) state_next = LAUNCH;
      end
      LAUNCH: begin
        start      = 1'b1;
        state_next = RUNNING;
      end
      RUNNING: begin
        if (done) state_next = RETIRE;
      end
      RETIRE: begin
        finished_warp_id = warp_id;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // PC is left in place on retire; only the warp id and lane mask are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      thread_mask <= '0;
      warp_id     <= NO_WARP;
    end else if (state == IDLE && grant) begin
      pc          <= kernel.start_pc;
      thread_mask <= lane_mask(kernel.thread_count);
      warp_id     <= kernel.warp_id;
    end else if (state == RETIRE) begin
      thread_mask <= '0;
      warp_id     <= NO_WARP;
    end
  end
endmodule

// File: rtl/warp_dispatcher.sv
// rtl/warp_dispatcher.sv - queues launched kernels and hands them round-robin to idle SIMD cores
// Optional perf counters: define WARP_DISPATCHER_PERF_EN.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        valid_kernel,
  input  kernel_t                                     kernel_in,
  input  logic [NUM_SIMD_CORES-1:0]                   core_done,
  output logic                                        dispatch_ready,
  output logic [NUM_SIMD_CORES-1:0]                   core_start,
  output logic [NUM_SIMD_CORES-1:0][31:0]             core_pc,
  output logic [NUM_SIMD_CORES-1:0][THREAD_COUNT-1:0] core_thread_mask,
  output logic [NUM_SIMD_CORES-1:0][3:0]              core_warp_id,
  output logic [NUM_SIMD_CORES-1:0][3:0]              finished_warp_id,
  output logic                                        overflow
`ifdef WARP_DISPATCHER_PERF_EN
  ,
  output logic [31:0]                                 perf_dispatched,
  output logic [31:0]                                 perf_stall_cycles
`endif
);
  kernel_t                     head;
  logic                        full;
  logic                        empty;
  logic                        accept;
  logic [NUM_SIMD_CORES-1:0]   idle_vec;
  logic [NUM_SIMD_CORES-1:0]   grant_vec;
  logic                        grant_valid;
  logic [LOG2_SIMD_CORES-1:0]  grant_idx;
  logic [LOG2_SIMD_CORES-1:0]  rr;

  // Invalid descriptors never reach the queue, so they can neither launch nor overflow it.
  assign accept = valid_kernel && (kernel_in.thread_count != '0) && (kernel_in.warp_id != NO_WARP);

  circular_buffer #(
    .SIZE (FIFO_DEPTH),
    .T    (kernel_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .data_in  (kernel_in),
    .pop      (grant_valid),
    .data_out (head),
    .full     (full),
    .empty    (empty)
  );

  assign dispatch_ready = !full;

  always_comb begin
    logic [LOG2_SIMD_CORES-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    cand        = '0;
    if (!empty) begin
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        cand = rr + i[LOG2_SIMD_CORES-1:0];
        if (!grant_valid && idle_vec[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    grant_vec[grant_idx] = grant_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= '0;
      overflow <= 1'b0;
    end else begin
      if (grant_valid)                  rr       <= grant_idx + 1'b1;
      if (accept && full && !grant_valid) overflow <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SIMD_CORES; g++) begin : g_slot
    core_slot u_slot (
      .clk              (clk),
      .rst              (rst),
      .grant            (grant_vec[g]),
      .kernel           (head),
      .done             (core_done[g]),
      .idle             (idle_vec[g]),
      .start            (core_start[g]),
      .pc               (core_pc[g]),
      .thread_mask      (core_thread_mask[g]),
      .warp_id          (core_warp_id[g]),
      .finished_warp_id (finished_warp_id[g])
    );
  end

`ifdef WARP_DISPATCHER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dispatched   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (grant_valid && perf_dispatched != '1)
        perf_dispatched <= perf_dispatched + 32'd1;
      if (!empty && idle_vec == '0 && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_warp_dispatcher.sv
// tb/tb_warp_dispatcher.sv - directed + random bench for warp_dispatcher against a cycle-numbered reference model
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  logic            clk;
  logic            rst;
  logic            valid_kernel;
  kernel_t         kernel_in;
  logic [3:0]      core_done;
  logic            dispatch_ready;
  logic [3:0]      core_start;
  logic [3:0][31:0] core_pc;
  logic [3:0][7:0] core_thread_mask;
  logic [3:0][3:0] core_warp_id;
  logic [3:0][3:0] finished_warp_id;
  logic            overflow;
`ifdef WARP_DISPATCHER_PERF_EN
  logic [31:0]     perf_dispatched;
  logic [31:0]     perf_stall_cycles;
`endif

  warp_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .valid_kernel     (valid_kernel),
    .kernel_in        (kernel_in),
    .core_done        (core_done),
    .dispatch_ready   (dispatch_ready),
    .core_start       (core_start),
    .core_pc          (core_pc),
    .core_thread_mask (core_thread_mask),
    .core_warp_id     (core_warp_id),
    .finished_warp_id (finished_warp_id),
    .overflow         (overflow)
`ifdef WARP_DISPATCHER_PERF_EN
    ,
    .perf_dispatched  (perf_dispatched),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each warp is described by the cycle numbers of its launch and retire.
  typedef struct {
    bit      has;
    kernel_t k;
    int      start_cyc;
    int      retire_cyc;
  } slot_m_t;

  slot_m_t     slots [4];
  kernel_t     q [$];
  int          rr_m;
  bit          ovf_m;
  logic [31:0] last_pc [4];
  int          cyc;

  function automatic kernel_t mk(input logic [31:0] pc, input int tc, input int id);
    kernel_t k;
    k.start_pc     = pc;
    k.thread_count = tc[2:0];
    k.warp_id      = id[3:0];
    return k;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      slots[k].has        = 0;
      slots[k].start_cyc  = -10;
      slots[k].retire_cyc = -10;
      last_pc[k]          = 32'h0;
    end
    q.delete();
    rr_m  = 0;
    ovf_m = 0;
    cyc   = 0;
  endtask

  task automatic model_check();
    logic [3:0]       e_start;
    logic [3:0][3:0]  e_fin;
    logic [3:0][3:0]  e_id;
    logic [3:0][7:0]  e_mask;
    logic [3:0][31:0] e_pc;
    int               m;
    for (int k = 0; k < 4; k++) begin
      m          = (1 << int'(slots[k].k.thread_count)) - 1;
      e_start[k] = slots[k].has && (cyc == slots[k].start_cyc);
      e_fin[k]   = (slots[k].has && cyc == slots[k].retire_cyc) ? slots[k].k.warp_id : 4'hF;
      e_id[k]    = slots[k].has ? slots[k].k.warp_id : 4'hF;
      e_mask[k]  = slots[k].has ? m[7:0] : 8'h00;
      e_pc[k]    = last_pc[k];
    end
    check("core_start", 128'(core_start), 128'(e_start));
    check("finished_warp_id", 128'(finished_warp_id), 128'(e_fin));
    check("core_warp_id", 128'(core_warp_id), 128'(e_id));
    check("core_thread_mask", 128'(core_thread_mask), 128'(e_mask));
    check("core_pc", 128'(core_pc), 128'(e_pc));
    check("dispatch_ready", 128'(dispatch_ready), 128'(q.size() < 4));
    check("overflow", 128'(overflow), 128'(ovf_m));
  endtask

  task automatic model_edge(input bit v, input kernel_t kin, input logic [3:0] d);
    int g;
    int c;
    g = -1;
    if (q.size() > 0) begin
      for (int i = 0; i < 4; i++) begin
        c = (rr_m + i) % 4;
        if (g < 0 && !slots[c].has) g = c;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (slots[k].has && cyc == slots[k].retire_cyc)
        slots[k].has = 0;
      else if (slots[k].has && slots[k].retire_cyc < 0 && cyc > slots[k].start_cyc && d[k])
        slots[k].retire_cyc = cyc + 1;
    end
    if (g >= 0) begin
      slots[g].has        = 1;
      slots[g].k          = q.pop_front();
      slots[g].start_cyc  = cyc + 1;
      slots[g].retire_cyc = -1;
      last_pc[g]          = slots[g].k.start_pc;
      rr_m                = (g + 1) % 4;
    end
    if (v && kin.thread_count != 0 && kin.warp_id != 4'hF) begin
      if (q.size() < 4) q.push_back(kin);
      else              ovf_m = 1;
    end
    cyc++;
  endtask

  task automatic step(input bit v, input kernel_t kin, input logic [3:0] d);
    valid_kernel = v;
    kernel_in    = kin;
    core_done    = d;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge(v, kin, d);
    #1;
    valid_kernel = 1'b0;
    kernel_in    = '0;
    core_done    = 4'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 4'b0);
  endtask

  // Reset takes effect asynchronously; values are sampled before the next clock edge.
  task automatic do_reset();
    valid_kernel = 1'b0;
    kernel_in    = '0;
    core_done    = 4'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_core_start", 128'(core_start), 128'(4'b0));
    check("rst_warp_id", 128'(core_warp_id), 128'(16'hFFFF));
    check("rst_finished", 128'(finished_warp_id), 128'(16'hFFFF));
    check("rst_mask", 128'(core_thread_mask), 128'(32'h0));
    check("rst_pc", 128'(core_pc), 128'(0));
    check("rst_ready", 128'(dispatch_ready), 128'(1'b1));
    check("rst_overflow", 128'(overflow), 128'(1'b0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    valid_kernel = 1'b0;
    kernel_in    = '0;
    core_done    = 4'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single kernel: launch latency, lane mask and one-cycle finish report.
    step(1'b1, mk(32'h100, 5, 2), 4'b0);
    check("single_no_early_start", 128'(core_start), 128'(4'b0000));
    idle(1);
    check("single_start", 128'(core_start), 128'(4'b0001));
    check("single_pc", 128'(core_pc[0]), 128'(32'h100));
    check("single_mask", 128'(core_thread_mask[0]), 128'(8'h1F));
    check("single_id", 128'(core_warp_id[0]), 128'(4'd2));
    idle(3);
    step(1'b0, '0, 4'b0001);
    check("single_finished", 128'(finished_warp_id), 128'(16'hFFF2));
    idle(1);
    check("single_finished_once", 128'(finished_warp_id), 128'(16'hFFFF));
    check("single_retired_id", 128'(core_warp_id[0]), 128'(4'hF));

    // Filtering: zero-thread and reserved-id kernels are discarded.
    step(1'b1, mk(32'h200, 0, 3), 4'b0);
    step(1'b1, mk(32'h300, 7, 15), 4'b0);
    idle(3);
    check("filter_no_launch", 128'(core_warp_id), 128'(16'hFFFF));
    check("filter_overflow", 128'(overflow), 128'(1'b0));

    // Round-robin fill, then overflow with every core busy.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'h1000 + i, 7, i), 4'b0);
    idle(3);
    check("rr_ids", 128'(core_warp_id), 128'(16'h3210));
    check("rr_mask7", 128'(core_thread_mask[3]), 128'(8'h7F));
    for (int i = 4; i < 8; i++) step(1'b1, mk(32'h2000 + i, 3, i), 4'b0);
    check("ovf_ready_low", 128'(dispatch_ready), 128'(1'b0));
    check("ovf_not_yet", 128'(overflow), 128'(1'b0));
    step(1'b1, mk(32'h2008, 3, 8), 4'b0);
    check("ovf_set", 128'(overflow), 128'(1'b1));
    idle(3);
    check("ovf_sticky", 128'(overflow), 128'(1'b1));

    // Core 2 retires; the queued head launches on it two cycles after retire.
    step(1'b0, '0, 4'b0100);
    check("rr_retire2", 128'(finished_warp_id[2]), 128'(4'd2));
    idle(1);
    check("rr_relaunch_not_yet", 128'(core_start), 128'(4'b0000));
    idle(1);
    check("rr_relaunch", 128'(core_start), 128'(4'b0100));
    check("rr_relaunch_id", 128'(core_warp_id[2]), 128'(4'd4));

    // Simultaneous retire on 1 and 3; core 2 is launching and ignores done.
    step(1'b0, '0, 4'b1110);
    check("simul_finished", 128'(finished_warp_id), 128'(16'h3F1F));
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 60,
           mk($urandom, $urandom_range(0, 7), $urandom_range(0, 15)),
           {$urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20});
    end

    // Reset in the middle of traffic, then more traffic from a clean state.
    do_reset();
    idle(4);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 45,
           mk($urandom, $urandom_range(0, 7), $urandom_range(0, 15)),
           {$urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
